// File: rtl/hist_frame_scheduler_if.sv
// Handshake bundle between the frame scheduler, the top-level controller and
// the input (histogram/CDF) and output (remap) stages.
// Ports: start/num_frames/done/busy/err face the controller; input_* and
//   cdf_* face the input stage; output_*, cdf_min_out and divisor face the
//   output stage. master = scheduler view, slave = environment view.
interface hist_frame_scheduler_if #(
  parameter int CW = 20,
  parameter int FW = 8
);
  logic          start;
  logic [FW-1:0] num_frames;
  logic          input_start;
  logic          input_done;
  logic          cdf_valid;
  logic [CW-1:0] cdf_min;
  logic          input_base_offset;
  logic          output_start;
  logic          output_done;
  logic          output_base_offset;
  logic [CW-1:0] cdf_min_out;
  logic [CW-1:0] divisor;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    input  start, num_frames, input_done, cdf_valid, cdf_min, output_done,
    output input_start, input_base_offset, output_start, output_base_offset,
           cdf_min_out, divisor, busy, done, err
  );

  modport slave (
    output start, num_frames, input_done, cdf_valid, cdf_min, output_done,
    input  input_start, input_base_offset, output_start, output_base_offset,
           cdf_min_out, divisor, busy, done, err
  );
endinterface

// File: rtl/hist_frame_scheduler.sv
// Multi-frame sequencer for histogram equalisation: ping-pongs two banks so the
//   input stage of frame k+1 overlaps the output stage of frame k.
// Latency: every launch/done pulse appears one cycle after the event enabling it.
// Backpressure: input launch waits for a free bank; output launch waits for a full bank.
// Ports: clock, reset (sync, active-high); bus (master modport) carries start/
//   num_frames/busy/done/err, input stage start/done/cdf/bank, output stage
//   start/done/bank/cdf_min_out/divisor.
module hist_frame_scheduler #(
  parameter int PIXELS = 16384,
  parameter int CW     = 20,
  parameter int FW     = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  hist_frame_scheduler_if.master bus
);

  // One extra bit so the frame counters never wrap, even for N = 2^FW - 1.
  localparam int CNTW = FW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state;
  logic [FW-1:0]   n_frames;
  logic [CNTW-1:0] in_cnt;
  logic [CNTW-1:0] out_cnt;
  logic            in_active;
  logic            out_active;
  logic [1:0]      full;
  logic [CW-1:0]   cdf_bank [2];
  logic            got_cdf;

  // Registered outputs
  logic          input_start_q;
  logic          input_off_q;
  logic          output_start_q;
  logic          output_off_q;
  logic [CW-1:0] cdf_out_q;
  logic [CW-1:0] divisor_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  // Post-event view of this cycle: launch decisions look at the state as it
  // will be after this cycle's done/cdf pulses, so a launch lands exactly one
  // cycle after the done pulse that enabled it and never shares its cycle.
  logic            in_fin;
  logic            out_fin;
  logic            got_eff;
  logic [1:0]      full_nx;
  logic [CW-1:0]   cdf_nx [2];
  logic [CNTW-1:0] in_cnt_nx;
  logic [CNTW-1:0] out_cnt_nx;
  logic            in_act_nx;
  logic            out_act_nx;
  logic            in_bank_nx;
  logic            out_bank_nx;
  logic            finish_run;
  logic            launch_in;
  logic            launch_out;
  logic [CW-1:0]   sel_cdf;
  logic [CW:0]     div_wide;
  logic [CW-1:0]   div_val;

  always_comb begin
    // Stage pulses only count while that stage is active (implies RUN).
    in_fin    = in_active & bus.input_done;
    out_fin   = out_active & bus.output_done;
    got_eff   = got_cdf | (in_active & bus.cdf_valid);

    full_nx   = full;
    cdf_nx[0] = cdf_bank[0];
    cdf_nx[1] = cdf_bank[1];
    if (in_active && bus.cdf_valid) begin
      cdf_nx[in_cnt[0]] = bus.cdf_min;
    end
    if (in_fin) begin
      full_nx[in_cnt[0]] = 1'b1;
      // A frame that never reported its CDF minimum remaps with cdf = 0.
      if (!got_eff) begin
        cdf_nx[in_cnt[0]] = '0;
      end
    end
    // The two stages can never be finishing on the same bank: the input stage
    // only writes an empty bank and the output stage only reads a full one.
    if (out_fin) begin
      full_nx[out_cnt[0]] = 1'b0;
    end

    in_cnt_nx   = in_cnt + {{FW{1'b0}}, in_fin};
    out_cnt_nx  = out_cnt + {{FW{1'b0}}, out_fin};
    in_act_nx   = in_active & ~in_fin;
    out_act_nx  = out_active & ~out_fin;
    in_bank_nx  = in_cnt_nx[0];
    out_bank_nx = out_cnt_nx[0];

    finish_run  = (state == S_RUN) && (out_cnt_nx == {1'b0, n_frames});
    launch_in   = (state == S_RUN) && !finish_run && !in_act_nx &&
                  (in_cnt_nx < {1'b0, n_frames}) && !full_nx[in_bank_nx];
    launch_out  = (state == S_RUN) && !finish_run && !out_act_nx &&
                  full_nx[out_bank_nx];

    // Divisor in CW+1 bits so cdf >= PIXELS shows up as zero or negative;
    // clamp those to 1 so the remap never divides by zero.
    sel_cdf  = cdf_nx[out_bank_nx];
    div_wide = (CW + 1)'(PIXELS) - {1'b0, sel_cdf};
    div_val  = (div_wide[CW] || (div_wide == '0)) ? CW'(1) : div_wide[CW-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      n_frames       <= '0;
      in_cnt         <= '0;
      out_cnt        <= '0;
      in_active      <= 1'b0;
      out_active     <= 1'b0;
      full           <= '0;
      cdf_bank[0]    <= '0;
      cdf_bank[1]    <= '0;
      got_cdf        <= 1'b0;
      input_start_q  <= 1'b0;
      input_off_q    <= 1'b0;
      output_start_q <= 1'b0;
      output_off_q   <= 1'b0;
      cdf_out_q      <= '0;
      divisor_q      <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      input_start_q  <= 1'b0;
      output_start_q <= 1'b0;
      done_q         <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            err_q <= 1'b0;
            if (bus.num_frames == '0) begin
              // Empty job: acknowledge with a done pulse, never go busy.
              done_q <= 1'b1;
            end else begin
              // Frame 0 launches straight from the start acceptance; bank 0
              // is empty here because every previous frame was drained.
              state         <= S_RUN;
              n_frames      <= bus.num_frames;
              in_cnt        <= '0;
              out_cnt       <= '0;
              full          <= '0;
              in_active     <= 1'b1;
              out_active    <= 1'b0;
              got_cdf       <= 1'b0;
              input_start_q <= 1'b1;
              input_off_q   <= 1'b0;
              busy_q        <= 1'b1;
            end
          end
        end

        S_RUN: begin
          in_cnt      <= in_cnt_nx;
          out_cnt     <= out_cnt_nx;
          full        <= full_nx;
          cdf_bank[0] <= cdf_nx[0];
          cdf_bank[1] <= cdf_nx[1];
          got_cdf     <= got_eff;
          in_active   <= in_act_nx;
          out_active  <= out_act_nx;
          if (in_fin && !got_eff) begin
            err_q <= 1'b1;
          end
          if (finish_run) begin
            state  <= S_DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
          if (launch_in) begin
            input_start_q <= 1'b1;
            in_active     <= 1'b1;
            input_off_q   <= in_bank_nx;
            got_cdf       <= 1'b0;
          end
          if (launch_out) begin
            output_start_q <= 1'b1;
            out_active     <= 1'b1;
            output_off_q   <= out_bank_nx;
            cdf_out_q      <= sel_cdf;
            divisor_q      <= div_val;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.input_start        = input_start_q;
  assign bus.input_base_offset  = input_off_q;
  assign bus.output_start       = output_start_q;
  assign bus.output_base_offset = output_off_q;
  assign bus.cdf_min_out        = cdf_out_q;
  assign bus.divisor            = divisor_q;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
  assign bus.err                = err_q;

endmodule

// File: tb/tb_hist_frame_scheduler.sv
// Bench for hist_frame_scheduler: plays the controller and both pipeline
// stages with randomized delays, keeps a frame-level reference model and
// compares every output on every cycle, plus directed literal scenarios.
module tb_hist_frame_scheduler;
  localparam int CW      = 20;
  localparam int FW      = 8;
  localparam int PIXELS  = 16384;
  localparam int CDF_MAX = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  hist_frame_scheduler_if #(.CW(CW), .FW(FW)) bus ();
  hist_frame_scheduler #(.PIXELS(PIXELS), .CW(CW), .FW(FW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: frame-level bookkeeping
  int m_state = 0;  // 0 idle, 1 run, 2 done
  int m_n = 0, m_in = 0, m_out = 0;
  bit m_in_busy = 0, m_out_busy = 0, m_got = 0;
  int cdf_of [256];
  bit e_in_start = 0, e_in_off = 0, e_out_start = 0, e_out_off = 0;
  bit e_busy = 0, e_done = 0, e_err = 0;
  int e_cdf = 0, e_div = 0;

  // Responder / control
  int in_cd = 0, out_cd = 0, cv_pt = -1;
  int in_lo = 2, in_hi = 4, out_lo = 2, out_hi = 4;
  int cv_pct = 100, stray_pct = 0, sstart_pct = 0;
  int cdf_q[$];
  bit req_rst = 0, req_start = 0, req_stray_in = 0, req_stray_out = 0;
  int req_nf = 0;

  // Logs
  int in_start_cyc[$], in_offs[$], out_start_cyc[$], out_offs[$];
  int out_cdfs[$], out_divs[$], in_done_cyc[$], out_done_cyc[$];
  int start_cyc = 0, done_cyc = 0;
  bit saw_done = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < 0 || i >= q.size()) return -1;
    return q[i];
  endfunction

  function automatic int next_cdf();
    if (cdf_q.size() > 0) return cdf_q.pop_front();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, PIXELS));
      1: return int'($urandom_range(PIXELS, CDF_MAX));
      2: return ($urandom_range(0, 1) != 0) ? PIXELS : 0;
      default: return int'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic model_step(bit rst, bit st, int nf, bit idn, bit cv, int cmin, bit odn);
    bit fin_in, fin_out;
    e_in_start = 0; e_out_start = 0; e_done = 0;
    if (rst) begin
      m_state = 0; m_n = 0; m_in = 0; m_out = 0;
      m_in_busy = 0; m_out_busy = 0; m_got = 0;
      e_in_off = 0; e_out_off = 0; e_cdf = 0; e_div = 0;
      e_busy = 0; e_err = 0;
      return;
    end
    case (m_state)
      0: if (st) begin
        e_err = 0;
        if (nf == 0) e_done = 1;
        else begin
          m_n = nf; m_in = 0; m_out = 0; m_state = 1; e_busy = 1;
          m_in_busy = 1; m_out_busy = 0; m_got = 0;
          e_in_start = 1; e_in_off = 0;
        end
      end
      2: m_state = 0;
      default: begin
        fin_in  = m_in_busy && idn;
        fin_out = m_out_busy && odn;
        if (m_in_busy && cv) begin cdf_of[m_in] = cmin; m_got = 1; end
        if (fin_in) begin
          if (!m_got) begin e_err = 1; cdf_of[m_in] = 0; end
          m_in++; m_in_busy = 0;
        end
        if (fin_out) begin m_out++; m_out_busy = 0; end
        if (m_out == m_n) begin
          m_state = 2; e_done = 1; e_busy = 0;
        end else begin
          // Two banks: input may run while fewer than two frames await output.
          if (!m_in_busy && m_in < m_n && (m_in - m_out) < 2) begin
            m_in_busy = 1; m_got = 0; e_in_start = 1; e_in_off = m_in[0];
          end
          if (!m_out_busy && m_out < m_in) begin
            m_out_busy = 1; e_out_start = 1; e_out_off = m_out[0];
            e_cdf = cdf_of[m_out];
            e_div = (cdf_of[m_out] >= PIXELS) ? 1 : PIXELS - cdf_of[m_out];
          end
        end
      end
    endcase
  endtask

  task automatic tick();
    bit st, idn, cv, odn, rs;
    int nf, cmin, d;
    @(negedge clock);
    cyc++;
    chk("cyc_input_start", bus.input_start, e_in_start);
    chk("cyc_input_base_offset", bus.input_base_offset, e_in_off);
    chk("cyc_output_start", bus.output_start, e_out_start);
    chk("cyc_output_base_offset", bus.output_base_offset, e_out_off);
    chk("cyc_cdf_min_out", bus.cdf_min_out, e_cdf);
    chk("cyc_divisor", bus.divisor, e_div);
    chk("cyc_busy", bus.busy, e_busy);
    chk("cyc_done", bus.done, e_done);
    chk("cyc_err", bus.err, e_err);
    if (bus.input_start === 1'b1) begin
      in_start_cyc.push_back(cyc); in_offs.push_back(int'(bus.input_base_offset));
    end
    if (bus.output_start === 1'b1) begin
      out_start_cyc.push_back(cyc); out_offs.push_back(int'(bus.output_base_offset));
      out_cdfs.push_back(int'(bus.cdf_min_out)); out_divs.push_back(int'(bus.divisor));
    end
    if (bus.done === 1'b1) begin saw_done = 1; done_cyc = cyc; end

    rs = req_rst; req_rst = 0;
    st = req_start; nf = req_nf; req_start = 0;
    idn = 0; cv = 0; odn = 0;
    cmin = int'($urandom_range(0, CDF_MAX));
    if (rs) begin
      in_cd = 0; out_cd = 0; cv_pt = -1;
    end else begin
      if (in_cd > 0) begin
        in_cd--;
        if (in_cd == 0) begin idn = 1; in_done_cyc.push_back(cyc); end
        else if (in_cd == cv_pt) begin cv = 1; cmin = next_cdf(); end
      end
      if (out_cd > 0) begin
        out_cd--;
        if (out_cd == 0) begin odn = 1; out_done_cyc.push_back(cyc); end
      end
      if (bus.input_start === 1'b1) begin
        d = int'($urandom_range(in_lo, in_hi));
        in_cd = d;
        cv_pt = (int'($urandom_range(1, 100)) <= cv_pct) ? int'($urandom_range(1, d - 1)) : -1;
      end
      if (bus.output_start === 1'b1) out_cd = int'($urandom_range(out_lo, out_hi));
      // Pulses while a stage is idle must be ignored.
      if (in_cd == 0 && !idn && bus.input_start !== 1'b1) begin
        if (int'($urandom_range(1, 100)) <= stray_pct) idn = 1;
        if (int'($urandom_range(1, 100)) <= stray_pct) cv = 1;
      end
      if (out_cd == 0 && !odn && bus.output_start !== 1'b1 &&
          int'($urandom_range(1, 100)) <= stray_pct) odn = 1;
      if (req_stray_in) begin idn = 1; cv = 1; req_stray_in = 0; end
      if (req_stray_out) begin odn = 1; req_stray_out = 0; end
      if (!st && int'($urandom_range(1, 100)) <= sstart_pct) begin
        st = 1; nf = int'($urandom_range(0, 5));
      end
    end
    reset = rs;
    bus.start = st;
    bus.num_frames = nf[FW-1:0];
    bus.input_done = idn;
    bus.cdf_valid = cv;
    bus.cdf_min = cmin[CW-1:0];
    bus.output_done = odn;
    model_step(rs, st, nf, idn, cv, cmin, odn);
  endtask

  task automatic clear_log();
    in_start_cyc.delete(); in_offs.delete(); out_start_cyc.delete(); out_offs.delete();
    out_cdfs.delete(); out_divs.delete(); in_done_cyc.delete(); out_done_cyc.delete();
    saw_done = 0;
  endtask

  task automatic start_run(int nf);
    clear_log();
    req_start = 1; req_nf = nf;
    tick();
    start_cyc = cyc;
  endtask

  task automatic run_until_done(int budget, string name);
    int k = 0;
    while (!saw_done && k < budget) begin tick(); k++; end
    chk({name, "_done_seen"}, saw_done, 1);
  endtask

  task automatic set_delays(int il, int ih, int ol, int oh);
    in_lo = il; in_hi = ih; out_lo = ol; out_hi = oh;
  endtask

  initial begin
    bit coinc;
    int nf;
    bus.start = 0; bus.num_frames = 0; bus.input_done = 0;
    bus.cdf_valid = 0; bus.cdf_min = 0; bus.output_done = 0;

    // Reset state
    req_rst = 1; tick();
    tick();
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_err", bus.err, 0);
    chk("reset_divisor", bus.divisor, 0);
    chk("reset_cdf_min_out", bus.cdf_min_out, 0);

    // Single frame, cdf_min = 100
    set_delays(4, 4, 3, 3); cv_pct = 100; cdf_q = '{100};
    start_run(1);
    run_until_done(200, "t1");
    chk("t1_in_start_latency", qget(in_start_cyc, 0) - start_cyc, 1);
    chk("t1_in_bank", qget(in_offs, 0), 0);
    chk("t1_out_after_in_done", qget(out_start_cyc, 0) - qget(in_done_cyc, 0), 1);
    chk("t1_divisor", qget(out_divs, 0), 16284);
    chk("t1_model_divisor", e_div, 16284);
    chk("t1_cdf_min_out", qget(out_cdfs, 0), 100);
    chk("t1_done_after_out_done", done_cyc - qget(out_done_cyc, 0), 1);
    tick();
    chk("t1_busy_after", bus.busy, 0);

    // Slow output stage, N = 3
    set_delays(3, 3, 20, 20); cdf_q = '{500, 600, 700};
    start_run(3);
    run_until_done(400, "t2");
    chk("t2_in_banks", {qget(in_offs, 0), qget(in_offs, 1), qget(in_offs, 2)} == {32'd0, 32'd1, 32'd0}, 1);
    chk("t2_out_banks", {qget(out_offs, 0), qget(out_offs, 1), qget(out_offs, 2)} == {32'd0, 32'd1, 32'd0}, 1);
    chk("t2_cdf0", qget(out_cdfs, 0), 500);
    chk("t2_cdf1", qget(out_cdfs, 1), 600);
    chk("t2_cdf2", qget(out_cdfs, 2), 700);
    chk("t2_overlap", qget(in_start_cyc, 1) < qget(out_done_cyc, 0), 1);
    chk("t2_in2_stall", qget(in_start_cyc, 2) - qget(out_done_cyc, 0), 1);

    // Divisor boundaries
    set_delays(3, 3, 3, 3); cdf_q = '{16384, 0, 16383, CDF_MAX};
    start_run(4);
    run_until_done(300, "t3");
    chk("t3_div_full", qget(out_divs, 0), 1);
    chk("t3_div_zero", qget(out_divs, 1), 16384);
    chk("t3_div_one", qget(out_divs, 2), 1);
    chk("t3_div_max", qget(out_divs, 3), 1);
    tick();

    // Missing cdf_valid -> err, cdf 0
    cv_pct = 0; cdf_q.delete();
    start_run(1);
    run_until_done(200, "t4");
    chk("t4_cdf_min_out", qget(out_cdfs, 0), 0);
    chk("t4_divisor", qget(out_divs, 0), 16384);
    repeat (5) tick();
    chk("t4_err_sticky", bus.err, 1);
    cv_pct = 100;
    start_run(1);
    tick();
    chk("t4_err_cleared", bus.err, 0);
    run_until_done(200, "t4b");
    tick();

    // Coincident input_done/output_done, N = 4
    set_delays(3, 3, 3, 3);
    start_run(4);
    run_until_done(300, "t5");
    coinc = 0;
    foreach (in_done_cyc[i]) foreach (out_done_cyc[j])
      if (in_done_cyc[i] == out_done_cyc[j]) coinc = 1;
    chk("t5_coincident_dones", coinc, 1);
    chk("t5_output_starts", out_start_cyc.size(), 4);
    chk("t5_done_cycle", done_cyc - start_cyc, 21);
    tick();

    // Zero-frame start
    start_run(0);
    tick();
    chk("n0_done", bus.done, 1);
    chk("n0_busy", bus.busy, 0);
    tick();
    chk("n0_done_once", bus.done, 0);

    // Reset mid-run, stray pulses, clean restart
    set_delays(3, 5, 4, 6);
    start_run(4);
    begin
      int k = 0;
      while (out_start_cyc.size() < 2 && k < 300) begin tick(); k++; end
    end
    chk("t6_reached_frame2", out_start_cyc.size() >= 2, 1);
    tick();
    req_rst = 1; tick();
    tick();
    chk("t6_busy", bus.busy, 0);
    chk("t6_cdf_min_out", bus.cdf_min_out, 0);
    chk("t6_divisor", bus.divisor, 0);
    req_stray_out = 1; req_stray_in = 1; tick();
    tick();
    chk("t6_no_launch", bus.output_start, 0);
    start_run(2);
    run_until_done(300, "t6b");
    chk("t6_output_starts", out_start_cyc.size(), 2);
    chk("t6_err", bus.err, 0);
    tick();

    // Randomized runs
    for (int r = 0; r < 25; r++) begin
      nf = int'($urandom_range(1, 8));
      set_delays(2, int'($urandom_range(2, 8)), int'($urandom_range(2, 3)), int'($urandom_range(3, 9)));
      cv_pct = 90; stray_pct = 5; sstart_pct = 3;
      start_run(nf);
      run_until_done(2000, "rand");
      chk("rand_output_starts", out_start_cyc.size(), nf);
      sstart_pct = 0;
      repeat (3) tick();
    end
    stray_pct = 0; cv_pct = 100;

    // Longest job: counters must not wrap
    set_delays(2, 3, 2, 3);
    start_run(255);
    run_until_done(5000, "n255");
    chk("n255_output_starts", out_start_cyc.size(), 255);
    chk("n255_input_starts", in_start_cyc.size(), 255);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
